// File: rtl/afifo_pkg.sv
// Shared helpers for the dual-clock FIFO halves: Gray conversion and
// pointer-width derivation. Functions work on 32-bit vectors; callers
// cast to their own pointer width.
package afifo_pkg;

  function automatic int unsigned addr_width(input int unsigned depth);
    return $clog2(depth);
  endfunction

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = g;
    for (int i = 1; i < 32; i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/afifo_sync_bus.sv
// Plain flop chain for bringing a Gray-coded bus across a clock boundary.
// Only safe for buses that change at most one bit per source-clock step.
module afifo_sync_bus #(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned STAGES = 2
) (
  input  logic             i_clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_sync [STAGES];

  // Shift the asynchronous bus through STAGES flops; cleared on reset.
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        r_sync[i] <= '0;
      end
    end else begin
      r_sync[0] <= i_d;
      for (int i = 1; i < STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/afifo_wr_ctrl.sv
// Write-domain half of the dual-clock FIFO. Owns the binary/Gray write
// pointer, drives the RAM write port, and derives full, level and
// almost-full against the synchronised read pointer. Full release lags
// a read by the synchroniser depth plus one edge, which is always safe.
module afifo_wr_ctrl
  import afifo_pkg::*;
#(
  parameter  int unsigned WIDTH       = 8,
  parameter  int unsigned DEPTH       = 16,
  parameter  int unsigned SYNC_STAGES = 2,
  parameter  int unsigned AF_THRESH   = 12,
  localparam int unsigned AW          = addr_width(DEPTH),
  localparam int unsigned PW          = AW + 1
) (
  input  logic             wclk,
  input  logic             rst_n,
  input  logic             winc,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PW-1:0]    rptr_gray,
  input  logic             ovf_clr,
  output logic             ram_wenc,
  output logic [AW-1:0]    ram_waddr,
  output logic [WIDTH-1:0] ram_wdata,
  output logic [PW-1:0]    wptr_gray,
  output logic             wfull,
  output logic             almost_full,
  output logic [PW-1:0]    wlevel,
  output logic             overflow
);

  logic [PW-1:0] r_wbin;
  logic [PW-1:0] r_wgray;
  logic          r_wfull;
  logic          r_af;
  logic [PW-1:0] r_wlevel;
  logic          r_ovf;

  logic          w_push;
  logic [PW-1:0] w_wbin_next;
  logic [PW-1:0] w_wgray_next;
  logic [PW-1:0] w_rq;
  logic [PW-1:0] w_rbin;
  logic [PW-1:0] w_full_gray;
  logic [PW-1:0] w_level_next;

  afifo_sync_bus #(
    .WIDTH  (PW),
    .STAGES (SYNC_STAGES)
  ) u_rptr_sync (
    .i_clk (wclk),
    .rst_n (rst_n),
    .i_d   (rptr_gray),
    .o_q   (w_rq)
  );

  // Writes are suppressed while reset is asserted so the RAM never sees a
  // stray enable from a producer that is already requesting.
  assign w_push       = winc & ~r_wfull & rst_n;
  assign w_wbin_next  = r_wbin + PW'(w_push);
  assign w_wgray_next = PW'(bin2gray(32'(w_wbin_next)));
  assign w_rbin       = PW'(gray2bin(32'(w_rq)));
  // Full when the write pointer is exactly one lap ahead: in Gray that is
  // the read pointer with its top two bits inverted.
  assign w_full_gray  = {~w_rq[AW:AW-1], w_rq[AW-2:0]};
  assign w_level_next = w_wbin_next - w_rbin;

  // Pointer registers: binary for addressing, Gray for the crossing.
  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) begin
      r_wbin  <= '0;
      r_wgray <= '0;
    end else begin
      r_wbin  <= w_wbin_next;
      r_wgray <= w_wgray_next;
    end
  end

  // Status flags evaluated on the post-push pointer so a write and a read
  // advance in the same cycle are folded into one compare.
  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) begin
      r_wfull  <= 1'b0;
      r_af     <= 1'b0;
      r_wlevel <= '0;
    end else begin
      r_wfull  <= (w_wgray_next == w_full_gray);
      r_af     <= (w_level_next >= PW'(AF_THRESH));
      r_wlevel <= w_level_next;
    end
  end

  // Sticky overflow on a write attempt into a full FIFO; clear has priority.
  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (ovf_clr) begin
      r_ovf <= 1'b0;
    end else if (winc && r_wfull) begin
      r_ovf <= 1'b1;
    end
  end

  assign ram_wenc    = w_push;
  assign ram_waddr   = r_wbin[AW-1:0];
  assign ram_wdata   = wdata;
  assign wptr_gray   = r_wgray;
  assign wfull       = r_wfull;
  assign almost_full = r_af;
  assign wlevel      = r_wlevel;
  assign overflow    = r_ovf;

endmodule

// File: tb/tb_afifo_wr_ctrl.sv
// Directed bench for the FIFO write controller: reset, fill/almost-full/
// overflow table, pessimistic full release, async reset mid-run and a
// pointer-wrap run with the read pointer tracking the write pointer.
module tb_afifo_wr_ctrl;

  logic       wclk;
  logic       rst_n;
  logic       winc;
  logic [7:0] wdata;
  logic [4:0] rptr_gray;
  logic       ovf_clr;
  logic       ram_wenc;
  logic [3:0] ram_waddr;
  logic [7:0] ram_wdata;
  logic [4:0] wptr_gray;
  logic       wfull;
  logic       almost_full;
  logic [4:0] wlevel;
  logic       overflow;

  int tests;
  int fails;

  afifo_wr_ctrl #(
    .WIDTH       (8),
    .DEPTH       (16),
    .SYNC_STAGES (2),
    .AF_THRESH   (12)
  ) dut (
    .wclk        (wclk),
    .rst_n       (rst_n),
    .winc        (winc),
    .wdata       (wdata),
    .rptr_gray   (rptr_gray),
    .ovf_clr     (ovf_clr),
    .ram_wenc    (ram_wenc),
    .ram_waddr   (ram_waddr),
    .ram_wdata   (ram_wdata),
    .wptr_gray   (wptr_gray),
    .wfull       (wfull),
    .almost_full (almost_full),
    .wlevel      (wlevel),
    .overflow    (overflow)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  typedef struct {
    logic       winc;
    logic       clr;
    logic [7:0] wd;
    logic       e_wenc;
    logic [3:0] e_addr;
    logic [4:0] e_gray;
    logic [4:0] e_lvl;
    logic       e_af;
    logic       e_full;
    logic       e_ovf;
  } vec_t;

  vec_t tbl [22];

  function automatic logic [4:0] g5(input int b);
    logic [4:0] v;
    v = 5'(b);
    return v ^ (v >> 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wfull"}, 32'(wfull), 0);
    chk({tag, "_af"}, 32'(almost_full), 0);
    chk({tag, "_wlevel"}, 32'(wlevel), 0);
    chk({tag, "_ovf"}, 32'(overflow), 0);
    chk({tag, "_wgray"}, 32'(wptr_gray), 0);
    chk({tag, "_waddr"}, 32'(ram_waddr), 0);
    chk({tag, "_wenc"}, 32'(ram_wenc), 0);
  endtask

  initial begin
    int wraps;
    logic [3:0] prev_addr;
    logic [4:0] prev_gray;

    tests = 0;
    fails = 0;

    //       winc clr  wd     wenc addr gray      lvl af full ovf
    tbl[0]  = '{1'b1, 1'b0, 8'h10, 1'b1, 4'd0,  5'd1,  5'd1,  1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 8'h11, 1'b1, 4'd1,  5'd3,  5'd2,  1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 8'h12, 1'b0, 4'd2,  5'd3,  5'd2,  1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 8'h13, 1'b1, 4'd2,  5'd2,  5'd3,  1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 8'h14, 1'b1, 4'd3,  5'd6,  5'd4,  1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 8'h15, 1'b1, 4'd4,  5'd7,  5'd5,  1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 8'h16, 1'b1, 4'd5,  5'd5,  5'd6,  1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 8'h17, 1'b1, 4'd6,  5'd4,  5'd7,  1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 8'h18, 1'b1, 4'd7,  5'd12, 5'd8,  1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 8'h19, 1'b1, 4'd8,  5'd13, 5'd9,  1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 8'h1A, 1'b1, 4'd9,  5'd15, 5'd10, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 8'h1B, 1'b1, 4'd10, 5'd14, 5'd11, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 8'h1C, 1'b1, 4'd11, 5'd10, 5'd12, 1'b1, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 8'h1D, 1'b1, 4'd12, 5'd11, 5'd13, 1'b1, 1'b0, 1'b0};
    tbl[14] = '{1'b1, 1'b0, 8'h1E, 1'b1, 4'd13, 5'd9,  5'd14, 1'b1, 1'b0, 1'b0};
    tbl[15] = '{1'b1, 1'b0, 8'h1F, 1'b1, 4'd14, 5'd8,  5'd15, 1'b1, 1'b0, 1'b0};
    tbl[16] = '{1'b1, 1'b0, 8'h20, 1'b1, 4'd15, 5'd24, 5'd16, 1'b1, 1'b1, 1'b0};
    tbl[17] = '{1'b1, 1'b0, 8'h21, 1'b0, 4'd0,  5'd24, 5'd16, 1'b1, 1'b1, 1'b1};
    tbl[18] = '{1'b1, 1'b1, 8'h22, 1'b0, 4'd0,  5'd24, 5'd16, 1'b1, 1'b1, 1'b0};
    tbl[19] = '{1'b1, 1'b0, 8'h23, 1'b0, 4'd0,  5'd24, 5'd16, 1'b1, 1'b1, 1'b1};
    tbl[20] = '{1'b0, 1'b0, 8'h24, 1'b0, 4'd0,  5'd24, 5'd16, 1'b1, 1'b1, 1'b1};
    tbl[21] = '{1'b0, 1'b1, 8'h25, 1'b0, 4'd0,  5'd24, 5'd16, 1'b1, 1'b1, 1'b0};

    // Reset held with the producer already requesting.
    rst_n     = 1'b0;
    winc      = 1'b1;
    wdata     = 8'h00;
    rptr_gray = 5'd0;
    ovf_clr   = 1'b0;
    #1;
    chk_all_zero("rst");
    repeat (3) @(posedge wclk);
    #1;
    chk_all_zero("rst_held");
    @(negedge wclk);
    winc  = 1'b0;
    rst_n = 1'b1;
    @(posedge wclk);
    #1;
    chk("post_rst_wfull", 32'(wfull), 0);
    chk("post_rst_wlevel", 32'(wlevel), 0);

    // Fill, almost-full threshold, overflow and its clear.
    for (int i = 0; i < 22; i++) begin
      @(negedge wclk);
      winc    = tbl[i].winc;
      ovf_clr = tbl[i].clr;
      wdata   = tbl[i].wd;
      #1;
      chk($sformatf("v%0d_wenc", i), 32'(ram_wenc), 32'(tbl[i].e_wenc));
      chk($sformatf("v%0d_waddr", i), 32'(ram_waddr), 32'(tbl[i].e_addr));
      chk($sformatf("v%0d_wdata", i), 32'(ram_wdata), 32'(tbl[i].wd));
      @(posedge wclk);
      #1;
      chk($sformatf("v%0d_wgray", i), 32'(wptr_gray), 32'(tbl[i].e_gray));
      chk($sformatf("v%0d_wlevel", i), 32'(wlevel), 32'(tbl[i].e_lvl));
      chk($sformatf("v%0d_af", i), 32'(almost_full), 32'(tbl[i].e_af));
      chk($sformatf("v%0d_wfull", i), 32'(wfull), 32'(tbl[i].e_full));
      chk($sformatf("v%0d_ovf", i), 32'(overflow), 32'(tbl[i].e_ovf));
    end

    // Full release: reader jumps to 4; wfull must stay up two edges, drop on the third.
    @(negedge wclk);
    winc      = 1'b0;
    ovf_clr   = 1'b0;
    rptr_gray = g5(4);
    for (int e = 1; e <= 3; e++) begin
      @(posedge wclk);
      #1;
      chk($sformatf("rel_e%0d_wfull", e), 32'(wfull), (e < 3) ? 32'd1 : 32'd0);
      chk($sformatf("rel_e%0d_wlevel", e), 32'(wlevel), (e < 3) ? 32'd16 : 32'd12);
    end
    chk("rel_af", 32'(almost_full), 1);

    // Asynchronous reset in the middle of a write burst.
    @(negedge wclk);
    winc = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    rptr_gray = 5'd0;
    @(negedge wclk);
    winc  = 1'b0;
    rst_n = 1'b1;

    // 40 writes with the reader chasing: two address wraps, Gray steps of one bit, never full.
    wraps     = 0;
    prev_addr = 4'd0;
    prev_gray = 5'd0;
    for (int i = 0; i < 40; i++) begin
      @(negedge wclk);
      winc  = 1'b1;
      wdata = 8'(i);
      #1;
      chk($sformatf("wrap%0d_waddr", i), 32'(ram_waddr), 32'(i % 16));
      chk($sformatf("wrap%0d_wenc", i), 32'(ram_wenc), 1);
      if (i > 0 && prev_addr == 4'd15 && ram_waddr == 4'd0) wraps++;
      prev_addr = ram_waddr;
      @(posedge wclk);
      #1;
      chk($sformatf("wrap%0d_wgray", i), 32'(wptr_gray), 32'(g5((i + 1) % 32)));
      chk($sformatf("wrap%0d_onebit", i), 32'($countones(wptr_gray ^ prev_gray)), 1);
      chk($sformatf("wrap%0d_wfull", i), 32'(wfull), 0);
      prev_gray = wptr_gray;
      rptr_gray = wptr_gray;
    end
    chk("wrap_count", 32'(wraps), 2);

    @(negedge wclk);
    winc = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
